div_seq_ctrl: RTL and testbench

- Multicycle sequencer for the CPU's signed 32-bit divide: one restoring-division step per clock instead of a fully unrolled combinational array.
- Accepts operands on a start pulse and holds busy while it iterates.
- Applies sign correction, then writes quotient (LO) and remainder (HI) with a one-cycle done pulse.
- Sits between the control unit (DIV instruction) and the HI/LO register inputs.

---
 rtl/div_defs_pkg.sv | 19 +
 rtl/div_step.sv | 26 ++
 rtl/div_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_defs_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand width and the step-counter width helper.
package div_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic           w_unused_msb;

  // R stays below the divisor between steps, so its top bit is always zero
  // and the shifted value still fits in WIDTH+1 bits.
  assign w_unused_msb = i_rem[WIDTH];
  assign w_rem_sh     = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  assign w_diff       = w_rem_sh - {1'b0, i_dvs};

  assign o_rem = w_diff[WIDTH] ? w_rem_sh : w_diff;
  assign o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multicycle signed divide sequencer (one restoring step per clock) feeding HI/LO.
// Optional macro DIV_ZERO_TRAP_EN: zero divisor short-cuts to FIX and flags div_zero.
module div_seq_ctrl
  import div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sn_dd;
  logic             r_sn_dv;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
`ifdef DIV_ZERO_TRAP_EN
  logic             r_zero;
  logic             r_dz;
`endif

  logic [WIDTH-1:0] w_abs_dd;
  logic [WIDTH-1:0] w_abs_dv;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  // Magnitudes as unsigned: the most negative value maps onto itself.
  assign w_abs_dd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_abs_dv = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_sn_dd <= 1'b0;
      r_sn_dv <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
`ifdef DIV_ZERO_TRAP_EN
      r_zero  <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      r_dz   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sn_dd <= dividend[WIDTH-1];
            r_sn_dv <= divisor[WIDTH-1];
            r_dvs   <= w_abs_dv;
            r_quo   <= w_abs_dd;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            r_zero  <= (divisor == '0);
            r_state <= (divisor == '0) ? ST_FIX : ST_RUN;
`else
            r_state <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= ST_FIX;
        end
        ST_FIX: begin
`ifdef DIV_ZERO_TRAP_EN
          // Q still holds |dividend|, so re-applying its sign returns it unchanged.
          if (r_zero) begin
            r_lo <= '1;
            r_hi <= r_sn_dd ? (~r_quo + 1'b1) : r_quo;
            r_dz <= 1'b1;
          end else begin
            r_lo <= (r_sn_dd ^ r_sn_dv) ? (~r_quo + 1'b1) : r_quo;
            r_hi <= r_sn_dd ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
          end
`else
          r_lo <= (r_sn_dd ^ r_sn_dv) ? (~r_quo + 1'b1) : r_quo;
          r_hi <= r_sn_dd ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign lo   = r_lo;
  assign hi   = r_hi;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero = r_dz;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomised and directed bench for div_seq_ctrl against an arithmetic model.
// Honours DIV_ZERO_TRAP_EN when computing zero-divisor expectations.
module tb_div_seq_ctrl;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clock;
  logic          clear;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;
  logic          div_zero;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] dd_tab [0:9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'd0, 32'd5, 32'd12,
                                 32'h7FFF_FFFF, 32'hFFFF_FFF4};
  logic [W-1:0] dv_tab [0:9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFF, 32'd5, 32'd9, 32'd0,
                                 32'd1, 32'd0};

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .lo       (lo),
    .hi       (hi),
    .div_zero (div_zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Truncating signed division; remainder carries the dividend's sign.
  function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    longint a, b, lq, lr;
    if (dv == 0) begin
`ifdef DIV_ZERO_TRAP_EN
      q = 32'hFFFF_FFFF;
      r = dd;
      dz = 1'b1;
`else
      q = dd[W-1] ? 32'd1 : 32'hFFFF_FFFF;
      r = dd;
      dz = 1'b0;
`endif
    end else begin
      a  = longint'($signed(dd));
      b  = longint'($signed(dv));
      lq = a / b;
      lr = a % b;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
      dz = 1'b0;
    end
  endfunction

  function automatic int exp_lat(input logic [W-1:0] dv);
`ifdef DIV_ZERO_TRAP_EN
    if (dv == 0) return 1;
`endif
    return LAT;
  endfunction

  // Pulses start for one edge and waits (bounded) for done.
  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         output int lat, output int bc, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic dz, output bit to);
    @(negedge clock);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    bc = busy ? 1 : 0;
    lat = 0; to = 1'b0; q = '0; r = '0; dz = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) begin
        q = lo; r = hi; dz = div_zero;
        break;
      end
      if (busy) bc++;
    end
    if (!done) to = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    n_vec++;
    if ({busy, done, div_zero, lo, hi} !== '0) begin
      n_err++;
      $display("FAIL reset_held: got busy=%b done=%b dz=%b lo=%h hi=%h want all 0", busy, done, div_zero, lo, hi);
    end
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    n_vec++;
    if ({busy, done, div_zero, lo, hi} !== '0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b done=%b dz=%b lo=%h hi=%h want all 0", busy, done, div_zero, lo, hi);
    end
  endtask

  task automatic check_one(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv);
    int lat, bc;
    logic [W-1:0] q, r, eq, er;
    logic dz, edz;
    bit to;
    run_div(dd, dv, lat, bc, q, r, dz, to);
    model(dd, dv, eq, er, edz);
    $display("%s: %h / %h -> lo=%h hi=%h dz=%b lat=%0d", tag, dd, dv, q, r, dz, lat);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL %s timeout: no done within 100 edges, want %0d", tag, exp_lat(dv));
    end else begin
      n_vec++;
      if (lat != exp_lat(dv)) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat(dv)); end
      n_vec++;
      if (bc != exp_lat(dv)) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, bc, exp_lat(dv)); end
      n_vec++;
      if (q !== eq) begin n_err++; $display("FAIL %s lo: got %h want %h", tag, q, eq); end
      n_vec++;
      if (r !== er) begin n_err++; $display("FAIL %s hi: got %h want %h", tag, r, er); end
      n_vec++;
      if (dz !== edz) begin n_err++; $display("FAIL %s div_zero: got %b want %b", tag, dz, edz); end
      @(posedge clock);
      #1;
      n_vec++;
      if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s after_done: got done=%b dz=%b busy=%b want 0 0 0", tag, done, div_zero, busy);
      end
      n_vec++;
      if (lo !== eq || hi !== er) begin
        n_err++;
        $display("FAIL %s hold: got lo=%h hi=%h want %h %h", tag, lo, hi, eq, er);
      end
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 10; i++) check_one($sformatf("dir%0d", i), dd_tab[i], dv_tab[i]);
  endtask

  task automatic test_random();
    logic [W-1:0] dd, dv;
    int x;
    for (int i = 0; i < 40; i++) begin
      dd = $urandom;
      dv = $urandom;
      case ($urandom_range(0, 3))
        1: begin
          x = int'($urandom_range(0, 2000)) - 1000; dd = x;
          x = int'($urandom_range(0, 40)) - 20;     dv = x;
        end
        2: dv = '0;
        3: begin
          dd = 32'h8000_0000;
          if ($urandom_range(0, 1) == 1) dv = 32'hFFFF_FFFF;
        end
        default: ;
      endcase
      check_one($sformatf("rnd%0d", i), dd, dv);
    end
  endtask

  task automatic test_mid_start();
    logic [W-1:0] eq, er;
    logic edz;
    int lat, nd;
    model(32'd100, 32'd7, eq, er, edz);
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) break;
      if (lat == 10) begin start = 1'b1; dividend = 32'd999; divisor = 32'd3; end
      if (lat == 11) begin start = 1'b0; dividend = $urandom; divisor = $urandom; end
    end
    $display("mid_start: lo=%h hi=%h lat=%0d", lo, hi, lat);
    n_vec++;
    if (!done || lat != LAT) begin n_err++; $display("FAIL mid_start latency: got %0d done=%b want %0d", lat, done, LAT); end
    n_vec++;
    if (lo !== eq || hi !== er) begin n_err++; $display("FAIL mid_start result: got %h %h want %h %h", lo, hi, eq, er); end
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (done || busy) nd++;
    end
    n_vec++;
    if (nd != 0) begin n_err++; $display("FAIL mid_start queued: got %0d busy/done cycles want 0", nd); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eq, er, eq2, er2;
    logic edz;
    int lat, bc;
    logic [W-1:0] q, r;
    logic dz;
    bit to;
    model(32'd4000, 32'hFFFF_FFFD, eq, er, edz);
    model(32'hFFFF_FC18, 32'd7, eq2, er2, edz);
    run_div(32'd4000, 32'hFFFF_FFFD, lat, bc, q, r, dz, to);
    // Still inside the done cycle: issue the next divide immediately.
    dividend = 32'hFFFF_FC18; divisor = 32'd7; start = 1'b1;
    $display("b2b first: lo=%h hi=%h lat=%0d", q, r, lat);
    n_vec++;
    if (to || q !== eq || r !== er) begin n_err++; $display("FAIL b2b_first: got %h %h to=%b want %h %h", q, r, to, eq, er); end
    @(posedge clock);
    #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept busy: got %b want 1", busy); end
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) break;
    end
    $display("b2b second: lo=%h hi=%h lat=%0d", lo, hi, lat);
    n_vec++;
    if (!done || lat != LAT) begin n_err++; $display("FAIL b2b_second latency: got %0d done=%b want %0d", lat, done, LAT); end
    n_vec++;
    if (lo !== eq2 || hi !== er2) begin n_err++; $display("FAIL b2b_second result: got %h %h want %h %h", lo, hi, eq2, er2); end
  endtask

  task automatic test_mid_reset();
    int nd;
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    $display("mid_reset: busy=%b done=%b lo=%h hi=%h", busy, done, lo, hi);
    n_vec++;
    if ({busy, done, div_zero, lo, hi} !== '0) begin
      n_err++;
      $display("FAIL mid_reset outputs: got busy=%b done=%b dz=%b lo=%h hi=%h want all 0", busy, done, div_zero, lo, hi);
    end
    @(negedge clock);
    clear = 1'b0;
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (done || busy) nd++;
    end
    n_vec++;
    if (nd != 0) begin n_err++; $display("FAIL mid_reset aborted: got %0d busy/done cycles want 0", nd); end
    check_one("after_reset", 32'd100, 32'd7);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_random();
    test_mid_start();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
